// File: rtl/dsp_pkg.sv
// Shared types and defaults for the DSP data-memory path.
// Holds the arbiter state encoding and bus width defaults.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int ADDR_W_D = 8;
  localparam int DATA_W_D = 16;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker for the data-memory arbiter.
// The pointer decides only when both ports request.
module dmem_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_win,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_win   = i_ptr;
    unique case (i_req)
      2'b01:   o_win = 1'b0;
      2'b10:   o_win = 1'b1;
      default: o_win = i_ptr;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port datamem.
// One ACCESS cycle per grant, registered read data, optional burst lock.
module dmem_arbiter
  import dsp_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BLAST =
    CW'(MAX_BURST - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              w_owner_n;
  logic              r_rr_ptr;
  logic [CW-1:0]     r_burst_cnt;
  logic [CW-1:0]     w_cnt_n;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0] w_req;
  logic [1:0] w_freq;
  logic       w_lock_own;
  logic       w_keep;
  logic       w_ptr;
  logic       w_win;
  logic       w_valid;

  assign w_req      = {req1, req0};
  assign w_lock_own = r_owner ? lock1 : lock0;

  // Locked owner keeps the port only until the burst budget runs out.
  assign w_keep = (r_state == DONE)
                & w_req[r_owner]
                & w_lock_own
                & (r_burst_cnt < BLAST);

  always_comb begin
    w_freq = w_req;
    if (r_state == DONE)
      w_freq[r_owner] = w_keep;
  end

  assign w_ptr = w_keep ? r_owner : r_rr_ptr;

  dmem_rr_pick u_pick (
    .i_req   (w_freq),
    .i_ptr   (w_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  always_comb begin
    w_next    = r_state;
    w_owner_n = r_owner;
    w_cnt_n   = r_burst_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next    = ACCESS;
          w_owner_n = w_win;
          w_cnt_n   = '0;
        end
      end
      ACCESS: w_next = DONE;
      DONE: begin
        if (w_valid) begin
          w_next    = ACCESS;
          w_owner_n = w_win;
          w_cnt_n   = w_keep
                    ? r_burst_cnt + CW'(1)
                    : '0;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_burst_cnt <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_owner     <= w_owner_n;
      r_burst_cnt <= w_cnt_n;
      if (r_state == ACCESS) begin
        r_rdata  <= mem_out;
        r_rr_ptr <= ~r_owner;
      end
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_in   = '0;
    if (r_state == ACCESS) begin
      mem_en   = (r_owner ? we1 : we0) & ~reset;
      mem_addr = r_owner ? addr1 : addr0;
      mem_in   = r_owner ? wdata1 : wdata0;
    end
  end

  assign ack0  = (r_state == DONE) & ~r_owner;
  assign ack1  = (r_state == DONE) &  r_owner;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural datamem.
// Expected acks are queued in order; a negedge monitor checks them.
module tb_dmem_arbiter;
  import dsp_pkg::*;

  typedef struct {
    logic        we;
    logic        lock;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic        lock0, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_in;
  logic [15:0] mem_out;

  logic [15:0] mem [0:255];

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_ack = 0;
  int   en_cnt = 0;
  txn_t txq0[$];
  txn_t txq1[$];
  exp_t expq[$];
  logic busy0, busy1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .lock0    (lock0),
    .lock1    (lock1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  assign mem_out = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem[mem_addr] <= mem_in;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_en) en_cnt++;
    if (ack0 || ack1) begin
      chk("one_ack", {31'd0, ack0 & ack1}, 32'd0);
      if (expq.size() == 0) begin
        chk("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("ack_port", {31'd0, ack1}, e.port);
        chk("ack_rdata", {16'd0, rdata}, {16'd0, e.data});
        if (e.gap >= 0)
          chk("ack_gap", cyc - last_ack, e.gap);
      end
      last_ack = cyc;
    end
  end

  task automatic push(input int p, input logic [15:0] d,
                      input int g);
    exp_t e;
    e.port = p;
    e.data = d;
    e.gap  = g;
    expq.push_back(e);
  endtask

  task automatic txn(input int p, input logic we,
                     input logic lk, input logic [7:0] a,
                     input logic [15:0] wd);
    txn_t t;
    t.we = we; t.lock = lk; t.addr = a; t.wdata = wd;
    if (p == 0) txq0.push_back(t);
    else        txq1.push_back(t);
  endtask

  task automatic load(input int p);
    txn_t t;
    if (p == 0) begin
      busy0 = txq0.size() != 0;
      req0  = busy0;
      if (busy0) begin
        t = txq0.pop_front();
        we0 = t.we; lock0 = t.lock;
        addr0 = t.addr; wdata0 = t.wdata;
      end
    end else begin
      busy1 = txq1.size() != 0;
      req1  = busy1;
      if (busy1) begin
        t = txq1.pop_front();
        we1 = t.we; lock1 = t.lock;
        addr1 = t.addr; wdata1 = t.wdata;
      end
    end
  endtask

  // Called at a negedge; drives both ports until their queues drain.
  task automatic run(input int budget);
    int n = 0;
    last_ack = cyc;
    load(0);
    load(1);
    while ((busy0 || busy1) && n < budget) begin
      @(negedge clk);
      n++;
      if (busy0 && ack0) load(0);
      if (busy1 && ack1) load(1);
    end
    if (busy0 || busy1) begin
      chk("run_timeout", n, 32'hFFFF_FFFF);
      req0 = 0; req1 = 0; busy0 = 0; busy1 = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_in"}, mem_in, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_state"}, dut.r_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 5; i++) mem[i] = 16'(i + 1);
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    lock0 = 0; lock1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; busy0 = 0; busy1 = 0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    reset = 0;
    @(negedge clk);

    en_cnt = 0;
    push(0, 16'h0003, 2);
    txn(0, 0, 0, 8'h02, 16'h0);
    run(20);
    chk("read_no_en", en_cnt, 0);

    en_cnt = 0;
    push(1, 16'h0000, 2);
    push(1, 16'hABCD, 3);
    txn(1, 1, 0, 8'h10, 16'hABCD);
    txn(1, 0, 0, 8'h10, 16'h0);
    run(20);
    chk("wr_en_cnt", en_cnt, 1);
    chk("wr_mem", mem[8'h10], 16'hABCD);

    do_reset();
    push(0, 16'h0001, 2);
    push(1, 16'h0002, 2);
    txn(0, 0, 0, 8'h00, 16'h0);
    txn(1, 0, 0, 8'h01, 16'h0);
    run(20);

    push(0, 16'h0003, 2);
    txn(0, 0, 0, 8'h02, 16'h0);
    run(20);
    push(1, 16'h0002, 2);
    push(0, 16'h0001, 2);
    txn(0, 0, 0, 8'h00, 16'h0);
    txn(1, 0, 0, 8'h01, 16'h0);
    run(20);

    do_reset();
    for (int i = 0; i < 4; i++) push(0, 16'(i + 1), 2);
    push(1, 16'h0005, 2);
    push(0, 16'h0005, 2);
    push(0, 16'h0000, 2);
    for (int i = 0; i < 6; i++)
      txn(0, 0, 1, 8'(i), 16'h0);
    txn(1, 0, 0, 8'h04, 16'h0);
    run(40);

    en_cnt = 0;
    req1 = 1; we1 = 1; lock1 = 0;
    addr1 = 8'h03; wdata1 = 16'h5555;
    @(negedge clk);
    chk("mid_state", dut.r_state, ACCESS);
    reset = 1; req1 = 0;
    @(negedge clk);
    chk_quiet("mid");
    reset = 0; we1 = 0;
    repeat (4) @(negedge clk);
    chk("mid_mem3", mem[3], 16'h0004);
    chk("mid_en_cnt", en_cnt, 0);

    chk("exp_left", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory (`datamem`: write enable, 8-bit address, 16-bit write data, combinational read data). Port 0 is the DSP core and port 1 is the host/DMA loader. Each requester uses a req/ack handshake. The block picks a winner round-robin, drives the memory for one access cycle, and returns registered read data with a one-cycle ack. An optional lock lets the owner run a bounded burst of back-to-back accesses.

## Interface
- `ADDR_W`, default 8, memory address width
- `DATA_W`, default 16, memory data width
- `MAX_BURST`, default 4, maximum consecutive locked accesses by one owner (≥1)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  access request, held until ack
- `we0`, `we1`  in  1  1 = write, 0 = read
- `lock0`, `lock1`  in  1  request to keep ownership for the next access
- `addr0`, `addr1`  in  ADDR_W  access address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  registered memory read data, valid while an ack is high
- `mem_en`  out  1  to `datamem.en`
- `mem_addr`  out  ADDR_W  to `datamem.addr`
- `mem_in`  out  DATA_W  to `datamem.in`
- `mem_out`  in  DATA_W  from `datamem.out`

## Operation
- FSM states: IDLE, ACCESS, DONE. Registers: `owner` (1b), `rr_ptr` (1b, favoured port), `burst_cnt` (0..MAX_BURST-1).
- IDLE
  - No req: stay in IDLE.
  - Any req: go to ACCESS. `owner` = winner, `burst_cnt` = 0.
  - Winner is the only requester, or `rr_ptr` if both request.
- ACCESS
  - `mem_addr` = addr[owner] and `mem_in` = wdata[owner].
  - `mem_en` = we[owner] & ~reset.
  - At the clock edge, `rdata` <= `mem_out` for both reads and writes; a write returns the pre-write content.
  - `rr_ptr` <= ~owner.
  - Next state: DONE.
- DONE: ack[owner] = 1. Arbitration uses a filtered request vector.
  - The owner's req counts only if lock[owner] = 1 and `burst_cnt` < MAX_BURST-1. In that case it is a new request: the requester must present new fields by the ACCESS cycle.
  - Otherwise the owner's req is ignored in this cycle, and a req from the same port in the next cycle is a new request.
  - Locked owner qualifies: it wins regardless of `rr_ptr`. Go to ACCESS with the same owner and `burst_cnt`+1.
  - Otherwise, if the other port requests: go to ACCESS, `owner` = other, `burst_cnt` = 0.
  - Otherwise: go to IDLE.
- Outside ACCESS, `mem_en`, `mem_addr` and `mem_in` are 0.
- Requester rule: req, we, addr, wdata and lock are held stable from req assertion through the ACCESS cycle.
- `burst_cnt` saturation forces a handover check. The locked owner gets no further access when the other port is waiting, which bounds starvation to MAX_BURST accesses.

## Timing
- Reset values: state IDLE, `owner` 0, `rr_ptr` 0, `burst_cnt` 0, `rdata` 0, ack0/ack1 0, `mem_en` 0, `mem_addr` 0, `mem_in` 0.
- Reset asserted in any state, including ACCESS: no memory write that cycle; next state IDLE; an in-flight access is dropped with no ack.
- Latency from idle: req seen in cycle 0, ACCESS in cycle 1, ack with `rdata` in cycle 2.
- Unlocked back-to-back accesses from alternating ports: one access per 2 cycles (ACCESS, DONE, ACCESS, ...).
- Locked burst: same cadence, 2 cycles per access, up to MAX_BURST accesses.
- Simultaneous req0 and req1 from IDLE after reset: port 0 wins.
- Ack is never high on both ports. Ack is high for exactly one cycle per access.

## Structure
- Shared package `dsp_pkg`: state enum (IDLE/ACCESS/DONE), default ADDR_W/DATA_W constants.
- One sub-module, `dmem_rr_pick`: 2-way round-robin picker taking the filtered request vector and `rr_ptr`, and returning the winner plus a valid flag. It is combinational. Everything else lives in `dmem_arbiter`.

## Test plan
- The bench instantiates `datamem` preloaded with mem[0..4] = 1..5.
- Single read: req0, we0 = 0, addr0 = 2 -> `mem_en` never 1; ack0 high in cycle 2 with `rdata` = 0x0003.
- Write then read: port 1 writes 0xABCD to addr 0x10, then port 1 reads addr 0x10 -> first ack1 `rdata` = old value; second ack1 `rdata` = 0xABCD.
- Contention: req0 and req1 both asserted from IDLE after reset, reading addrs 0 and 1 -> ack0 (`rdata` 1) first, then ack1 (`rdata` 2) two cycles later. Repeating the contention -> port 1 is served first.
- Locked burst: port 0 holds lock0 with addrs 0..5 while req1 is held high -> exactly 4 consecutive ack0s (`rdata` 1, 2, 3, 4), then ack1 before any fifth ack0.
- Reset mid-op: port 1 write of 0x5555 to addr 3 with reset asserted in its ACCESS cycle -> mem[3] stays 4, no ack1, state IDLE, all outputs 0.
